// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store initiator that sits between the datapath and a word-addressed data memory.
//   It accepts byte/half/word loads and stores at byte addresses over a valid/ready handshake.
//   Sub-word stores use read-modify-write. Loads extract the addressed lane and sign- or
//   zero-extend it. Misaligned, out-of-range and bad-size requests return an error and never
//   touch the memory.
//
// Ports
//   Clock, Resetn         rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_write/req_size    1 = store; 00 byte, 01 half, 10 word (11 is an error)
//   req_signed            loads only: sign-extend the extracted lane
//   req_addr/req_wdata    byte address and store data (low bits for sub-word stores)
//   resp_valid            one-cycle response strobe; qualifies resp_rdata and resp_err
//   mem_addr              word index (req_addr[31:2], zero-extended)
//   mem_data/mem_wr_en    write word and write enable (the memory writes on the rising edge)
//   mem_read_en/mem_q     read enable and combinational read data
module mem_access_unit #(
   parameter int unsigned MEM_WORDS = 32
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data,
   output logic        mem_wr_en,
   output logic        mem_read_en,
   input  logic [31:0] mem_q
);

   localparam logic [1:0] SizeByte = 2'b00;
   localparam logic [1:0] SizeHalf = 2'b01;
   localparam logic [1:0] SizeWord = 2'b10;
   localparam logic [1:0] SizeBad  = 2'b11;

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   // Returns the addressed lane of a memory word, extended to 32 bits.
   function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane,
                                                input logic        sgn);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SizeByte: r = {{24{sgn & b[7]}}, b};
         SizeHalf: r = {{16{sgn & h[15]}}, h};
         default:  r = word;
      endcase
      return r;
   endfunction

   // Replaces only the addressed lane(s) of the old word with the store data.
   function automatic logic [31:0] merge_lane(input logic [31:0] old_word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
      logic [31:0] r;
      r = old_word;
      case (size)
         SizeByte: r[{lane, 3'b000} +: 8] = wd[7:0];
         SizeHalf: begin
            if (lane[1]) r[31:16] = wd[15:0];
            else         r[15:0]  = wd[15:0];
         end
         default:  r = wd;
      endcase
      return r;
   endfunction

   state_e      state_q, state_d;

   // Latched request fields
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        sgn_q, sgn_d;
   logic [1:0]  lane_q, lane_d;
   logic [29:0] index_q, index_d;
   logic [31:0] wdata_q, wdata_d;

   // Registered outputs
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic        mem_wr_en_q, mem_wr_en_d;
   logic        mem_read_en_q, mem_read_en_d;

   logic        req_err;
   logic        accept;

   // Any of these makes the request an error; it then goes straight to RESP.
   assign req_err = (req_size == SizeBad)
                 || ((req_size == SizeHalf) && req_addr[0])
                 || ((req_size == SizeWord) && (req_addr[1:0] != 2'b00))
                 || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

   assign accept = (state_q == StIdle) && req_valid && req_ready_q;

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      size_d        = size_q;
      sgn_d         = sgn_q;
      lane_d        = lane_q;
      index_d       = index_q;
      wdata_d       = wdata_q;
      req_ready_d   = 1'b0;
      resp_valid_d  = 1'b0;
      resp_rdata_d  = 32'h0;
      resp_err_d    = 1'b0;
      mem_addr_d    = 32'h0;
      mem_data_d    = 32'h0;
      mem_wr_en_d   = 1'b0;
      mem_read_en_d = 1'b0;

      case (state_q)
         StIdle: begin
            if (accept) begin
               write_d = req_write;
               size_d  = req_size;
               sgn_d   = req_signed;
               lane_d  = req_addr[1:0];
               index_d = req_addr[31:2];
               wdata_d = req_wdata;
               if (req_err) begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_write && (req_size == SizeWord)) begin
                  state_d     = StWrite;
                  mem_wr_en_d = 1'b1;
                  mem_addr_d  = {2'b00, req_addr[31:2]};
                  mem_data_d  = req_wdata;
               end else begin
                  // Loads and sub-word stores both start with a read.
                  state_d       = StRead;
                  mem_read_en_d = 1'b1;
                  mem_addr_d    = {2'b00, req_addr[31:2]};
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         StRead: begin
            if (write_q) begin
               state_d     = StWrite;
               mem_wr_en_d = 1'b1;
               mem_addr_d  = {2'b00, index_q};
               mem_data_d  = merge_lane(mem_q, wdata_q, size_q, lane_q);
            end else begin
               state_d      = StResp;
               resp_valid_d = 1'b1;
               resp_rdata_d = extract_lane(mem_q, size_q, lane_q, sgn_q);
            end
         end
         StWrite: begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
         end
         StResp: begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Reset clears every output at once, so an aborted store's pending write is dropped.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q       <= StIdle;
         write_q       <= 1'b0;
         size_q        <= 2'b00;
         sgn_q         <= 1'b0;
         lane_q        <= 2'b00;
         index_q       <= 30'h0;
         wdata_q       <= 32'h0;
         req_ready_q   <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_rdata_q  <= 32'h0;
         resp_err_q    <= 1'b0;
         mem_addr_q    <= 32'h0;
         mem_data_q    <= 32'h0;
         mem_wr_en_q   <= 1'b0;
         mem_read_en_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         write_q       <= write_d;
         size_q        <= size_d;
         sgn_q         <= sgn_d;
         lane_q        <= lane_d;
         index_q       <= index_d;
         wdata_q       <= wdata_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_err_q    <= resp_err_d;
         mem_addr_q    <= mem_addr_d;
         mem_data_q    <= mem_data_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_read_en_q <= mem_read_en_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_err    = resp_err_q;
   assign mem_addr    = mem_addr_q;
   assign mem_data    = mem_data_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign mem_read_en = mem_read_en_q;

   // Structural invariants of the FSM outputs.
   a_rw_excl: assert property (@(posedge Clock) disable iff (!Resetn)
      !(mem_wr_en_q && mem_read_en_q));
   a_ready_idle: assert property (@(posedge Clock) disable iff (!Resetn)
      req_ready_q |-> (state_q == StIdle));
   a_resp_state: assert property (@(posedge Clock) disable iff (!Resetn)
      resp_valid_q |-> (state_q == StResp));

endmodule
